// File: rtl/mcu_block_sequencer_if.sv
// Block handshake plus the tag bundle describing the block about to be accepted.
interface mcu_block_sequencer_if #(
    parameter int unsigned DIM_W = 16,
    parameter int unsigned QID_W = 2
);
    logic             blk_valid;
    logic             blk_ready;
    logic [1:0]       tag_comp;
    logic [QID_W-1:0] tag_qid;
    logic [DIM_W-1:0] tag_blk_x;
    logic [DIM_W-1:0] tag_blk_y;
    logic [DIM_W-1:0] tag_mcu_x;
    logic [DIM_W-1:0] tag_mcu_y;
    logic             tag_dummy;
    logic             tag_last_in_mcu;

    modport master (
        input  blk_valid,
        output blk_ready, tag_comp, tag_qid, tag_blk_x, tag_blk_y,
               tag_mcu_x, tag_mcu_y, tag_dummy, tag_last_in_mcu
    );

    modport slave (
        output blk_valid,
        input  blk_ready, tag_comp, tag_qid, tag_blk_x, tag_blk_y,
               tag_mcu_x, tag_mcu_y, tag_dummy, tag_last_in_mcu
    );
endinterface

// File: rtl/mcu_block_sequencer.sv
// Block-order and tag generator: derives MCU geometry from the scan configuration
// and emits per-block component, quant id, coordinates, padding and end-of-MCU flags.
module mcu_block_sequencer #(
    parameter int unsigned MAX_COMP = 3,
    parameter int unsigned DIM_W    = 16,
    parameter int unsigned QID_W    = 2,
    parameter int unsigned MAX_BLK  = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_scan,
    input  logic [DIM_W-1:0]          img_width,
    input  logic [DIM_W-1:0]          img_height,
    input  logic [1:0]                num_comp,
    input  logic [3*MAX_COMP-1:0]     comp_h_samp_flat,
    input  logic [3*MAX_COMP-1:0]     comp_v_samp_flat,
    input  logic [QID_W*MAX_COMP-1:0] comp_qid_flat,
    mcu_block_sequencer_if.master     blk,
    output logic                      scan_done,
    output logic                      cfg_error
);
    localparam int unsigned EW = DIM_W + 3;

    typedef enum logic [2:0] {IDLE, CALC1, CALC2, RUN, DONE, ERROR} state_t;
    state_t state;

    logic [DIM_W-1:0] cfg_w, cfg_h;
    logic [1:0]       cfg_n;
    logic [2:0]       h_raw [MAX_COMP];
    logic [2:0]       v_raw [MAX_COMP];
    logic [QID_W-1:0] qid   [MAX_COMP];
    logic [1:0]       lh    [MAX_COMP];
    logic [1:0]       lv    [MAX_COMP];
    logic [1:0]       lhm, lvm;
    logic [DIM_W-1:0] mcus_x, mcus_y;
    logic [DIM_W-1:0] lim_x [MAX_COMP];
    logic [DIM_W-1:0] lim_y [MAX_COMP];

    logic [1:0]       cur_comp, sub_x, sub_y;
    logic [DIM_W-1:0] mcu_x, mcu_y;

    logic             ready_q, t_dummy, t_last;
    logic [1:0]       t_comp;
    logic [QID_W-1:0] t_qid;
    logic [DIM_W-1:0] t_bx, t_by, t_mx, t_my;

    logic             err_c;
    logic [1:0]       lh_c [MAX_COMP];
    logic [1:0]       lv_c [MAX_COMP];
    logic [1:0]       lhm_c, lvm_c;
    logic [5:0]       sum_c;
    logic [EW-1:0]    pw, ph;
    logic [DIM_W-1:0] mcus_x_c, mcus_y_c;
    logic [DIM_W-1:0] lim_x_c [MAX_COMP];
    logic [DIM_W-1:0] lim_y_c [MAX_COMP];

    logic             lsx, lsy, lcomp, lmx, lmy, scan_end;
    logic [1:0]       nx_comp, nx_sx, nx_sy, s_comp, s_sx, s_sy;
    logic [DIM_W-1:0] nx_mx, nx_my, s_mx, s_my, n_bx, n_by, use_lx, use_ly;
    logic             n_dummy, n_last;

    always_comb begin
        err_c = (cfg_n == 2'd0) || (32'(cfg_n) > MAX_COMP);
        lhm_c = '0;
        lvm_c = '0;
        sum_c = '0;
        for (int unsigned c = 0; c < MAX_COMP; c++) begin
            lh_c[c] = '0;
            lv_c[c] = '0;
            if (c < 32'(cfg_n)) begin
                case (h_raw[c])
                    3'd1:    lh_c[c] = 2'd0;
                    3'd2:    lh_c[c] = 2'd1;
                    3'd4:    lh_c[c] = 2'd2;
                    default: err_c = 1'b1;
                endcase
                case (v_raw[c])
                    3'd1:    lv_c[c] = 2'd0;
                    3'd2:    lv_c[c] = 2'd1;
                    3'd4:    lv_c[c] = 2'd2;
                    default: err_c = 1'b1;
                endcase
                if (lh_c[c] > lhm_c) lhm_c = lh_c[c];
                if (lv_c[c] > lvm_c) lvm_c = lv_c[c];
                sum_c = sum_c + (6'd1 << ({1'b0, lh_c[c]} + {1'b0, lv_c[c]}));
            end
        end
        if (cfg_n > 2'd1 && 32'(sum_c) > MAX_BLK) err_c = 1'b1;
        // A single-component scan is one block per MCU whatever its sampling factors
        if (cfg_n == 2'd1) begin
            lh_c[0] = '0;
            lv_c[0] = '0;
            lhm_c   = '0;
            lvm_c   = '0;
        end

        mcus_x_c = DIM_W'(({3'b000, cfg_w} + (EW'(8) << lhm) - EW'(1)) >> (32'd3 + 32'(lhm)));
        mcus_y_c = DIM_W'(({3'b000, cfg_h} + (EW'(8) << lvm) - EW'(1)) >> (32'd3 + 32'(lvm)));
        pw = '0;
        ph = '0;
        for (int unsigned c = 0; c < MAX_COMP; c++) begin
            pw = (({3'b000, cfg_w} << lh[c]) + (EW'(1) << lhm) - EW'(1)) >> lhm;
            ph = (({3'b000, cfg_h} << lv[c]) + (EW'(1) << lvm) - EW'(1)) >> lvm;
            lim_x_c[c] = DIM_W'((pw + EW'(7)) >> 3);
            lim_y_c[c] = DIM_W'((ph + EW'(7)) >> 3);
        end

        lsx      = sub_x == 2'((3'd1 << lh[cur_comp]) - 3'd1);
        lsy      = sub_y == 2'((3'd1 << lv[cur_comp]) - 3'd1);
        lcomp    = cur_comp == cfg_n - 2'd1;
        lmx      = mcu_x == mcus_x - DIM_W'(1);
        lmy      = mcu_y == mcus_y - DIM_W'(1);
        scan_end = lsx && lsy && lcomp && lmx && lmy;
        nx_comp  = cur_comp;
        nx_sx    = '0;
        nx_sy    = sub_y;
        nx_mx    = mcu_x;
        nx_my    = mcu_y;
        if (!lsx) begin
            nx_sx = sub_x + 2'd1;
        end else if (!lsy) begin
            nx_sy = sub_y + 2'd1;
        end else if (!lcomp) begin
            nx_sy   = '0;
            nx_comp = cur_comp + 2'd1;
        end else begin
            nx_sy   = '0;
            nx_comp = '0;
            if (!lmx) begin
                nx_mx = mcu_x + DIM_W'(1);
            end else begin
                nx_mx = '0;
                nx_my = mcu_y + DIM_W'(1);
            end
        end

        // Tags are computed for the position being loaded, so they are ready the cycle after
        s_comp = '0;
        s_sx   = '0;
        s_sy   = '0;
        s_mx   = '0;
        s_my   = '0;
        if (state == RUN) begin
            s_comp = nx_comp;
            s_sx   = nx_sx;
            s_sy   = nx_sy;
            s_mx   = nx_mx;
            s_my   = nx_my;
        end
        use_lx  = (state == CALC2) ? lim_x_c[s_comp] : lim_x[s_comp];
        use_ly  = (state == CALC2) ? lim_y_c[s_comp] : lim_y[s_comp];
        n_bx    = (s_mx << lh[s_comp]) + DIM_W'(s_sx);
        n_by    = (s_my << lv[s_comp]) + DIM_W'(s_sy);
        n_dummy = (n_bx >= use_lx) || (n_by >= use_ly);
        n_last  = (s_sx == 2'((3'd1 << lh[s_comp]) - 3'd1)) &&
                  (s_sy == 2'((3'd1 << lv[s_comp]) - 3'd1)) &&
                  (s_comp == cfg_n - 2'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cfg_w     <= '0;
            cfg_h     <= '0;
            cfg_n     <= '0;
            lhm       <= '0;
            lvm       <= '0;
            mcus_x    <= '0;
            mcus_y    <= '0;
            for (int unsigned c = 0; c < MAX_COMP; c++) begin
                h_raw[c] <= '0;
                v_raw[c] <= '0;
                qid[c]   <= '0;
                lh[c]    <= '0;
                lv[c]    <= '0;
                lim_x[c] <= '0;
                lim_y[c] <= '0;
            end
            cur_comp  <= '0;
            sub_x     <= '0;
            sub_y     <= '0;
            mcu_x     <= '0;
            mcu_y     <= '0;
            ready_q   <= 1'b0;
            t_comp    <= '0;
            t_qid     <= '0;
            t_bx      <= '0;
            t_by      <= '0;
            t_mx      <= '0;
            t_my      <= '0;
            t_dummy   <= 1'b0;
            t_last    <= 1'b0;
            scan_done <= 1'b0;
            cfg_error <= 1'b0;
        end else if (start_scan) begin
            state <= CALC1;
            cfg_w <= img_width;
            cfg_h <= img_height;
            cfg_n <= num_comp;
            for (int unsigned c = 0; c < MAX_COMP; c++) begin
                h_raw[c] <= comp_h_samp_flat[3*c +: 3];
                v_raw[c] <= comp_v_samp_flat[3*c +: 3];
                qid[c]   <= comp_qid_flat[QID_W*c +: QID_W];
            end
            cur_comp  <= '0;
            sub_x     <= '0;
            sub_y     <= '0;
            mcu_x     <= '0;
            mcu_y     <= '0;
            ready_q   <= 1'b0;
            scan_done <= 1'b0;
            cfg_error <= 1'b0;
        end else begin
            case (state)
                CALC1: begin
                    for (int unsigned c = 0; c < MAX_COMP; c++) begin
                        lh[c] <= lh_c[c];
                        lv[c] <= lv_c[c];
                    end
                    lhm <= lhm_c;
                    lvm <= lvm_c;
                    if (err_c) begin
                        cfg_error <= 1'b1;
                        state     <= ERROR;
                    end else begin
                        state <= CALC2;
                    end
                end
                CALC2: begin
                    mcus_x <= mcus_x_c;
                    mcus_y <= mcus_y_c;
                    for (int unsigned c = 0; c < MAX_COMP; c++) begin
                        lim_x[c] <= lim_x_c[c];
                        lim_y[c] <= lim_y_c[c];
                    end
                    t_comp  <= s_comp;
                    t_qid   <= qid[s_comp];
                    t_bx    <= n_bx;
                    t_by    <= n_by;
                    t_mx    <= s_mx;
                    t_my    <= s_my;
                    t_dummy <= n_dummy;
                    t_last  <= n_last;
                    ready_q <= 1'b1;
                    state   <= RUN;
                end
                RUN: begin
                    if (blk.blk_valid) begin
                        if (scan_end) begin
                            state     <= DONE;
                            scan_done <= 1'b1;
                            ready_q   <= 1'b0;
                        end else begin
                            cur_comp <= s_comp;
                            sub_x    <= s_sx;
                            sub_y    <= s_sy;
                            mcu_x    <= s_mx;
                            mcu_y    <= s_my;
                            t_comp   <= s_comp;
                            t_qid    <= qid[s_comp];
                            t_bx     <= n_bx;
                            t_by     <= n_by;
                            t_mx     <= s_mx;
                            t_my     <= s_my;
                            t_dummy  <= n_dummy;
                            t_last   <= n_last;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign blk.blk_ready       = ready_q;
    assign blk.tag_comp        = t_comp;
    assign blk.tag_qid         = t_qid;
    assign blk.tag_blk_x       = t_bx;
    assign blk.tag_blk_y       = t_by;
    assign blk.tag_mcu_x       = t_mx;
    assign blk.tag_mcu_y       = t_my;
    assign blk.tag_dummy       = t_dummy;
    assign blk.tag_last_in_mcu = t_last;
endmodule

// File: tb/tb_mcu_block_sequencer.sv
// Directed bench for mcu_block_sequencer: hand-computed block/tag sequences per scan config.
module tb_mcu_block_sequencer;
    logic        clk = 1'b0;
    logic        rst, start_scan;
    logic [15:0] img_width, img_height;
    logic [1:0]  num_comp;
    logic [8:0]  hf, vf;
    logic [5:0]  qf;
    logic        scan_done, cfg_error;

    always #5 clk = ~clk;

    mcu_block_sequencer_if #(.DIM_W(16), .QID_W(2)) bif ();

    mcu_block_sequencer #(.MAX_COMP(3), .DIM_W(16), .QID_W(2), .MAX_BLK(10)) dut (
        .clk              (clk),
        .rst              (rst),
        .start_scan       (start_scan),
        .img_width        (img_width),
        .img_height       (img_height),
        .num_comp         (num_comp),
        .comp_h_samp_flat (hf),
        .comp_v_samp_flat (vf),
        .comp_qid_flat    (qf),
        .blk              (bif.master),
        .scan_done        (scan_done),
        .cfg_error        (cfg_error)
    );

    typedef struct {
        int c, q, bx, by, mx, my, d, l;
    } blk_t;

    blk_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input int w, input int h, input int n,
                             input logic [8:0] hs, input logic [8:0] vs, input logic [5:0] qs);
        img_width  = 16'(w);
        img_height = 16'(h);
        num_comp   = 2'(n);
        hf         = hs;
        vf         = vs;
        qf         = qs;
    endtask

    task automatic pulse_start();
        start_scan = 1'b1;
        tick();
        start_scan = 1'b0;
    endtask

    task automatic push(input int c, input int q, input int bx, input int by,
                        input int mx, input int my, input int d, input int l);
        blk_t e;
        e = '{c, q, bx, by, mx, my, d, l};
        exp_q.push_back(e);
    endtask

    task automatic check_blk(input string nm, input blk_t e);
        check_eq({nm, ".ready"}, 32'(bif.blk_ready), 32'd1);
        check_eq({nm, ".comp"},  32'(bif.tag_comp), e.c);
        check_eq({nm, ".qid"},   32'(bif.tag_qid), e.q);
        check_eq({nm, ".bx"},    32'(bif.tag_blk_x), e.bx);
        check_eq({nm, ".by"},    32'(bif.tag_blk_y), e.by);
        check_eq({nm, ".mx"},    32'(bif.tag_mcu_x), e.mx);
        check_eq({nm, ".my"},    32'(bif.tag_mcu_y), e.my);
        check_eq({nm, ".dummy"}, 32'(bif.tag_dummy), e.d);
        check_eq({nm, ".last"},  32'(bif.tag_last_in_mcu), e.l);
    endtask

    // Streams every queued block back-to-back; one idle cycle before block stall_at
    task automatic run_expected(input string nm, input int stall_at);
        bif.blk_valid = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == stall_at) begin
                bif.blk_valid = 1'b0;
                tick();
                check_blk($sformatf("%s.stall%0d", nm, i), exp_q[i]);
                bif.blk_valid = 1'b1;
            end
            check_blk($sformatf("%s.b%0d", nm, i), exp_q[i]);
            tick();
        end
        bif.blk_valid = 1'b0;
        check_eq({nm, ".done"}, 32'(scan_done), 32'd1);
        check_eq({nm, ".done_ready"}, 32'(bif.blk_ready), 32'd0);
        exp_q.delete();
    endtask

    task automatic load_420_16();
        push(0, 0, 0, 0, 0, 0, 0, 0);
        push(0, 0, 1, 0, 0, 0, 0, 0);
        push(0, 0, 0, 1, 0, 0, 0, 0);
        push(0, 0, 1, 1, 0, 0, 0, 0);
        push(1, 1, 0, 0, 0, 0, 0, 0);
        push(2, 1, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        rst           = 1'b1;
        start_scan    = 1'b0;
        bif.blk_valid = 1'b0;
        configure(0, 0, 0, 9'd0, 9'd0, 6'd0);
        tick();
        tick();
        check_eq("rst.ready", 32'(bif.blk_ready), 32'd0);
        check_eq("rst.comp", 32'(bif.tag_comp), 32'd0);
        check_eq("rst.bx", 32'(bif.tag_blk_x), 32'd0);
        check_eq("rst.mx", 32'(bif.tag_mcu_x), 32'd0);
        check_eq("rst.last", 32'(bif.tag_last_in_mcu), 32'd0);
        check_eq("rst.done", 32'(scan_done), 32'd0);
        check_eq("rst.err", 32'(cfg_error), 32'd0);
        rst = 1'b0;
        bif.blk_valid = 1'b1;
        tick();
        check_eq("idle.ready", 32'(bif.blk_ready), 32'd0);
        bif.blk_valid = 1'b0;

        // 4:2:0, 16x16: Y 2x2, Cb/Cr 1x1
        configure(16, 16, 3, 9'b001_001_010, 9'b001_001_010, 6'b01_01_00);
        pulse_start();
        tick();
        tick();
        load_420_16();
        run_expected("t420", -1);
        bif.blk_valid = 1'b1;
        tick();
        bif.blk_valid = 1'b0;
        check_eq("t420.done_hold", 32'(scan_done), 32'd1);
        check_eq("t420.tag_hold", 32'(bif.tag_comp), 32'd2);

        // Cb H=3 is illegal
        configure(16, 16, 3, 9'b001_011_010, 9'b001_001_010, 6'b01_01_00);
        pulse_start();
        check_eq("err.cleared_done", 32'(scan_done), 32'd0);
        tick();
        tick();
        check_eq("err.flag", 32'(cfg_error), 32'd1);
        check_eq("err.ready", 32'(bif.blk_ready), 32'd0);
        bif.blk_valid = 1'b1;
        tick();
        bif.blk_valid = 1'b0;
        check_eq("err.ready_hold", 32'(bif.blk_ready), 32'd0);

        // 4:4:4, 24x8: legal restart clears the error
        configure(24, 8, 3, 9'b001_001_001, 9'b001_001_001, 6'b01_01_00);
        pulse_start();
        check_eq("t444.err_clr", 32'(cfg_error), 32'd0);
        tick();
        tick();
        for (int m = 0; m < 3; m++)
            for (int c = 0; c < 3; c++)
                push(c, (c == 0) ? 0 : 1, m, 0, m, 0, 0, (c == 2) ? 1 : 0);
        run_expected("t444", 4);

        // Grayscale: sampling factors 2x2 ignored, 20x9 -> 3x2 MCUs
        configure(20, 9, 1, 9'b001_001_010, 9'b001_001_010, 6'b00_00_11);
        pulse_start();
        tick();
        tick();
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 3; x++)
                push(0, 3, x, y, x, y, 0, 1);
        run_expected("gray", -1);

        // 4:2:0, 24x8: right-hand and lower Y blocks are padding
        configure(24, 8, 3, 9'b001_001_010, 9'b001_001_010, 6'b01_01_00);
        pulse_start();
        tick();
        tick();
        for (int m = 0; m < 2; m++) begin
            push(0, 0, 2*m,   0, m, 0, 0, 0);
            push(0, 0, 2*m+1, 0, m, 0, (m == 1) ? 1 : 0, 0);
            push(0, 0, 2*m,   1, m, 0, 1, 0);
            push(0, 0, 2*m+1, 1, m, 0, 1, 0);
            push(1, 1, m, 0, m, 0, 0, 0);
            push(2, 1, m, 0, m, 0, 0, 1);
        end
        run_expected("pad", -1);

        // Restart mid-scan, then reset mid-run
        configure(16, 16, 3, 9'b001_001_010, 9'b001_001_010, 6'b01_01_00);
        pulse_start();
        tick();
        tick();
        load_420_16();
        bif.blk_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_blk($sformatf("rs.b%0d", i), exp_q[i]);
            tick();
        end
        pulse_start();
        check_eq("rs.ready0", 32'(bif.blk_ready), 32'd0);
        tick();
        check_eq("rs.ready1", 32'(bif.blk_ready), 32'd0);
        tick();
        check_blk("rs.restart", exp_q[0]);
        tick();
        check_blk("rs.next", exp_q[1]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bif.blk_valid = 1'b0;
        check_eq("rs.rst_ready", 32'(bif.blk_ready), 32'd0);
        check_eq("rs.rst_bx", 32'(bif.tag_blk_x), 32'd0);
        check_eq("rs.rst_comp", 32'(bif.tag_comp), 32'd0);
        check_eq("rs.rst_done", 32'(scan_done), 32'd0);
        check_eq("rs.rst_err", 32'(cfg_error), 32'd0);
        exp_q.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
